// File: rtl/operand_collector_if.sv
// Operand collector port bundle.
// Producer valids/data in, collected operands and stall status out.
interface operand_collector_if #(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = 16,
  parameter int NS_W    = 8,
  parameter int CNT_W   = 8
);

  logic                      inst_valid;
  logic [NUM_SRC*NS_W-1:0]   src_dec;
  logic [NUM_SRC-1:0]        src_idx_lsb;

  logic [NUM_SRC-1:0]        interim_v;
  logic [NUM_SRC*DATA_W-1:0] interim_data;

  logic                      pe_neigh_v;
  logic                      pu_neigh_v;
  logic                      pe_bus_v;
  logic                      gb_bus_v;
  logic [DATA_W-1:0]         pe_neigh_data;
  logic [DATA_W-1:0]         pu_neigh_data;
  logic [DATA_W-1:0]         pe_bus_data;
  logic [DATA_W-1:0]         gb_bus_data;

  logic [NUM_SRC-1:0]        src_v_bram;
  logic [NUM_SRC*DATA_W-1:0] bram_data;

  logic [NUM_SRC-1:0]        op_v;
  logic [NUM_SRC*DATA_W-1:0] op_data;
  logic                      inst_fire;
  logic                      inst_stall;
  logic [CNT_W-1:0]          stall_cnt;
  logic                      timeout;

  modport master (
    output inst_valid,
    output src_dec,
    output src_idx_lsb,
    output interim_v,
    output interim_data,
    output pe_neigh_v,
    output pu_neigh_v,
    output pe_bus_v,
    output gb_bus_v,
    output pe_neigh_data,
    output pu_neigh_data,
    output pe_bus_data,
    output gb_bus_data,
    output src_v_bram,
    output bram_data,
    input  op_v,
    input  op_data,
    input  inst_fire,
    input  inst_stall,
    input  stall_cnt,
    input  timeout
  );

  modport slave (
    input  inst_valid,
    input  src_dec,
    input  src_idx_lsb,
    input  interim_v,
    input  interim_data,
    input  pe_neigh_v,
    input  pu_neigh_v,
    input  pe_bus_v,
    input  gb_bus_v,
    input  pe_neigh_data,
    input  pu_neigh_data,
    input  pe_bus_data,
    input  gb_bus_data,
    input  src_v_bram,
    input  bram_data,
    output op_v,
    output op_data,
    output inst_fire,
    output inst_stall,
    output stall_cnt,
    output timeout
  );

endinterface

// File: rtl/operand_collector.sv
// Operand collector: gathers per-source operands from several producers,
// holds early arrivals, fires when all are present, watches for stalls.
module operand_collector #(
  parameter int NUM_SRC     = 3,
  parameter int DATA_W      = 16,
  parameter int NS_W        = 8,
  parameter int NS_BUS      = 3,
  parameter int NS_NEIGHBOR = 4,
  parameter int NS_INTERIM  = 5,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 200
) (
  input logic               clk,
  input logic               reset,
  operand_collector_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_SRC-1:0][NS_W-1:0]   dec;
  logic [NUM_SRC-1:0][DATA_W-1:0] interim;
  logic [NUM_SRC-1:0][DATA_W-1:0] bram;

  logic [NUM_SRC-1:0]             req;
  logic [NUM_SRC-1:0]             arr;
  logic [NUM_SRC-1:0]             present;
  logic [NUM_SRC-1:0][DATA_W-1:0] live_data;

  logic [NUM_SRC-1:0]             held_q;
  logic [NUM_SRC-1:0]             held_d;
  logic [NUM_SRC-1:0][DATA_W-1:0] hold_data_q;
  logic [NUM_SRC-1:0][DATA_W-1:0] hold_data_d;

  logic [CNT_W-1:0]               stall_cnt_q;
  logic [CNT_W-1:0]               stall_cnt_d;
  logic                           timeout_q;
  logic                           timeout_d;

  logic                           fire;
  logic                           stall;
  logic [NUM_SRC-1:0]             op_v;
  logic [NUM_SRC-1:0][DATA_W-1:0] op_data;

  // Only three namespace bits matter; the rest of the decode is ignored.
  logic unused_dec;

  assign dec        = bus.src_dec;
  assign interim    = bus.interim_data;
  assign bram       = bus.bram_data;
  assign unused_dec = ^bus.src_dec;

  // Namespace decode: which sources need a producer and which one it is.
  always_comb begin
    req       = '0;
    arr       = '0;
    live_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      req[i] = dec[i][NS_BUS]
             | dec[i][NS_NEIGHBOR]
             | dec[i][NS_INTERIM];
      if (dec[i][NS_INTERIM]) begin
        arr[i]       = bus.interim_v[i];
        live_data[i] = interim[i];
      end else if (dec[i][NS_NEIGHBOR]) begin
        if (bus.src_idx_lsb[i]) begin
          arr[i]       = bus.pu_neigh_v;
          live_data[i] = bus.pu_neigh_data;
        end else begin
          arr[i]       = bus.pe_neigh_v;
          live_data[i] = bus.pe_neigh_data;
        end
      end else if (dec[i][NS_BUS]) begin
        if (bus.src_idx_lsb[i]) begin
          arr[i]       = bus.gb_bus_v;
          live_data[i] = bus.gb_bus_data;
        end else begin
          arr[i]       = bus.pe_bus_v;
          live_data[i] = bus.pe_bus_data;
        end
      end
    end
  end

  // Fire when every required source is either held or arriving now.
  always_comb begin
    present = held_q | (arr & {NUM_SRC{bus.inst_valid}});
    fire    = bus.inst_valid & (&(~req | present));
    stall   = bus.inst_valid & ~fire;
  end

  // Operand mux: held copy first, then live producer, then local memory.
  always_comb begin
    op_v    = '0;
    op_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      op_v[i] = bus.src_v_bram[i] | (req[i] & present[i]);
      if (held_q[i]) begin
        op_data[i] = hold_data_q[i];
      end else if (req[i]) begin
        op_data[i] = live_data[i];
      end else begin
        op_data[i] = bram[i];
      end
    end
  end

  // Capture first arrival while stalled; drop everything on fire or flush.
  always_comb begin
    held_d      = held_q;
    hold_data_d = hold_data_q;
    if (!bus.inst_valid || fire) begin
      held_d = '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (arr[i] && req[i] && !held_q[i]) begin
          held_d[i]      = 1'b1;
          hold_data_d[i] = live_data[i];
        end
      end
    end
  end

  // Saturating stall counter; timeout tracks the count it is loaded with.
  always_comb begin
    stall_cnt_d = '0;
    timeout_d   = 1'b0;
    if (stall) begin
      if (stall_cnt_q == CNT_MAX) begin
        stall_cnt_d = CNT_MAX;
      end else begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      timeout_d = (int'(stall_cnt_d) >= TIMEOUT);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_q      <= '0;
      hold_data_q <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      held_q      <= held_d;
      hold_data_q <= hold_data_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.op_v       = op_v;
  assign bus.op_data    = op_data;
  assign bus.inst_fire  = fire;
  assign bus.inst_stall = stall;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_operand_collector.sv
// Testbench for operand_collector.
// Directed scenarios, literal expectations plus a per-cycle reference model.
module tb_operand_collector;

  localparam int NS  = 3;
  localparam int DW  = 16;
  localparam int NW  = 8;
  localparam int CW  = 8;
  localparam int TO  = 5;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  operand_collector_if #(
    .NUM_SRC(NS), .DATA_W(DW), .NS_W(NW), .CNT_W(CW)
  ) ifc ();

  operand_collector #(
    .NUM_SRC(NS), .DATA_W(DW), .NS_W(NW),
    .NS_BUS(3), .NS_NEIGHBOR(4), .NS_INTERIM(5),
    .CNT_W(CW), .TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Namespace kinds: 0 local memory, 1 bus, 2 neighbour, 3 interim.
  function automatic int kind_of(input int i);
    logic [NW-1:0] d;
    d = ifc.src_dec[i*NW +: NW];
    if (d[5]) return 3;
    if (d[4]) return 2;
    if (d[3]) return 1;
    return 0;
  endfunction

  // Returns {valid, data} of the producer a source listens to.
  function automatic logic [DW:0] producer(input int i);
    bit l;
    l = ifc.src_idx_lsb[i];
    case (kind_of(i))
      3: return {ifc.interim_v[i], ifc.interim_data[i*DW +: DW]};
      2: return l ? {ifc.pu_neigh_v, ifc.pu_neigh_data}
                  : {ifc.pe_neigh_v, ifc.pe_neigh_data};
      1: return l ? {ifc.gb_bus_v, ifc.gb_bus_data}
                  : {ifc.pe_bus_v, ifc.pe_bus_data};
      default: return '0;
    endcase
  endfunction

  bit [NS-1:0]     m_have;
  logic [DW-1:0]   m_val [NS];
  int              m_cnt = 0;
  bit              m_to  = 0;

  logic [DW:0]         pr [NS];
  bit                  e_fire;
  logic [NS-1:0]       e_opv;
  logic [NS*DW-1:0]    e_opd;

  initial begin
    m_have = '0;
    for (int i = 0; i < NS; i++) m_val[i] = '0;
  end

  always @(negedge clk) begin
    e_fire = ifc.inst_valid;
    for (int i = 0; i < NS; i++) begin
      pr[i] = producer(i);
      if (kind_of(i) != 0 && !m_have[i] &&
          !(pr[i][DW] && ifc.inst_valid))
        e_fire = 1'b0;
      e_opv[i] = ifc.src_v_bram[i] ||
                 (kind_of(i) != 0 &&
                  (m_have[i] || (pr[i][DW] && ifc.inst_valid)));
      if (m_have[i])
        e_opd[i*DW +: DW] = m_val[i];
      else if (kind_of(i) != 0)
        e_opd[i*DW +: DW] = pr[i][DW-1:0];
      else
        e_opd[i*DW +: DW] = ifc.bram_data[i*DW +: DW];
    end
    if (!reset) begin
      chk("m_fire",  64'(ifc.inst_fire),  64'(e_fire));
      chk("m_stall", 64'(ifc.inst_stall),
          64'(ifc.inst_valid && !e_fire));
      chk("m_op_v",  64'(ifc.op_v),       64'(e_opv));
      chk("m_op_data", 64'(ifc.op_data),  64'(e_opd));
      chk("m_cnt",   64'(ifc.stall_cnt),  64'(m_cnt));
      chk("m_to",    64'(ifc.timeout),    64'(m_to));
    end
    if (reset) begin
      m_have = '0;
      for (int i = 0; i < NS; i++) m_val[i] = '0;
      m_cnt = 0;
      m_to  = 0;
    end else if (!ifc.inst_valid || e_fire) begin
      m_have = '0;
      m_cnt  = 0;
      m_to   = 0;
    end else begin
      for (int i = 0; i < NS; i++)
        if (kind_of(i) != 0 && pr[i][DW] && !m_have[i]) begin
          m_have[i] = 1'b1;
          m_val[i]  = pr[i][DW-1:0];
        end
      if (m_cnt < (1 << CW) - 1) m_cnt++;
      m_to = (m_cnt >= TO);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ns(input int i, input int kind, input bit lsb);
    logic [NW-1:0] d;
    d = '0;
    case (kind)
      1: d[3] = 1'b1;
      2: d[4] = 1'b1;
      3: d[5] = 1'b1;
      default: d = '0;
    endcase
    ifc.src_dec[i*NW +: NW] = d;
    ifc.src_idx_lsb[i]      = lsb;
  endtask

  task automatic clear_v();
    ifc.interim_v  = '0;
    ifc.pe_neigh_v = 1'b0;
    ifc.pu_neigh_v = 1'b0;
    ifc.pe_bus_v   = 1'b0;
    ifc.gb_bus_v   = 1'b0;
  endtask

  function automatic logic [DW-1:0] opd(input int i);
    return ifc.op_data[i*DW +: DW];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset             = 1'b1;
    ifc.inst_valid    = 1'b0;
    ifc.src_dec       = '0;
    ifc.src_idx_lsb   = '0;
    ifc.interim_data  = '0;
    ifc.pe_neigh_data = '0;
    ifc.pu_neigh_data = '0;
    ifc.pe_bus_data   = '0;
    ifc.gb_bus_data   = '0;
    ifc.src_v_bram    = '0;
    ifc.bram_data     = {16'h0777, 16'h0666, 16'h0555};
    clear_v();
    repeat (2) adv();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cnt", 64'(ifc.stall_cnt), 64'd0);
    chk("rst_to",  64'(ifc.timeout),   64'd0);
    chk("rst_fire", 64'(ifc.inst_fire), 64'd0);

    // Both operands arrive together: fire with no stall.
    adv();
    set_ns(0, 1, 1'b0);
    set_ns(1, 3, 1'b0);
    set_ns(2, 0, 1'b0);
    ifc.src_v_bram   = 3'b100;
    ifc.inst_valid   = 1'b1;
    ifc.pe_bus_v     = 1'b1;
    ifc.pe_bus_data  = 16'h0012;
    ifc.interim_v    = 3'b010;
    ifc.interim_data = {16'h0000, 16'h0034, 16'h0000};
    @(negedge clk);
    chk("t1_fire", 64'(ifc.inst_fire), 64'd1);
    chk("t1_op0",  64'(opd(0)), 64'h0012);
    chk("t1_op1",  64'(opd(1)), 64'h0034);
    chk("t1_op2",  64'(opd(2)), 64'h0777);
    chk("t1_opv",  64'(ifc.op_v), 64'b111);
    adv();
    ifc.inst_valid = 1'b0;
    clear_v();
    @(negedge clk);
    chk("t1_cnt", 64'(ifc.stall_cnt), 64'd0);

    // Neighbour then bus: capture, ignore later arrival, fire.
    adv();
    set_ns(0, 2, 1'b1);
    set_ns(1, 1, 1'b1);
    ifc.inst_valid    = 1'b1;
    ifc.pu_neigh_v    = 1'b1;
    ifc.pu_neigh_data = 16'h00AA;
    @(negedge clk);
    chk("t2_stall0", 64'(ifc.inst_stall), 64'd1);
    chk("t2_opv0",   64'(ifc.op_v), 64'b101);
    adv();
    ifc.pu_neigh_v    = 1'b0;
    ifc.pu_neigh_data = 16'h0011;
    @(negedge clk);
    chk("t2_held1", 64'(opd(0)), 64'h00AA);
    chk("t2_cnt1",  64'(ifc.stall_cnt), 64'd1);
    adv();
    ifc.pu_neigh_v    = 1'b1;
    ifc.pu_neigh_data = 16'h00CC;
    @(negedge clk);
    chk("t2_keep", 64'(opd(0)), 64'h00AA);
    adv();
    ifc.pu_neigh_v  = 1'b0;
    ifc.gb_bus_v    = 1'b1;
    ifc.gb_bus_data = 16'h00BB;
    @(negedge clk);
    chk("t2_fire", 64'(ifc.inst_fire), 64'd1);
    chk("t2_op0",  64'(opd(0)), 64'h00AA);
    chk("t2_op1",  64'(opd(1)), 64'h00BB);
    chk("t2_cnt3", 64'(ifc.stall_cnt), 64'd3);
    adv();
    ifc.gb_bus_v      = 1'b0;
    ifc.pu_neigh_data = 16'h0055;
    @(negedge clk);
    chk("t2_empty", 64'(ifc.op_v), 64'b100);
    chk("t2_live",  64'(opd(0)), 64'h0055);
    chk("t2_cnt0",  64'(ifc.stall_cnt), 64'd0);
    adv();
    ifc.inst_valid = 1'b0;

    // Flush mid-collection, then a fresh arrival is required.
    adv();
    ifc.inst_valid    = 1'b1;
    ifc.pu_neigh_v    = 1'b1;
    ifc.pu_neigh_data = 16'h00AA;
    adv();
    ifc.inst_valid = 1'b0;
    ifc.pu_neigh_v = 1'b0;
    adv();
    ifc.inst_valid    = 1'b1;
    ifc.gb_bus_v      = 1'b1;
    ifc.gb_bus_data   = 16'h00BB;
    ifc.pu_neigh_data = 16'h0066;
    @(negedge clk);
    chk("t3_stall", 64'(ifc.inst_stall), 64'd1);
    chk("t3_opv",   64'(ifc.op_v), 64'b110);
    chk("t3_cnt",   64'(ifc.stall_cnt), 64'd0);
    adv();
    ifc.pu_neigh_v    = 1'b1;
    ifc.pu_neigh_data = 16'h0077;
    ifc.gb_bus_data   = 16'h00EE;
    @(negedge clk);
    chk("t3_fire", 64'(ifc.inst_fire), 64'd1);
    chk("t3_op0",  64'(opd(0)), 64'h0077);
    chk("t3_op1",  64'(opd(1)), 64'h00BB);
    adv();
    ifc.inst_valid = 1'b0;
    clear_v();

    // Watchdog: two interim operands never arrive.
    adv();
    set_ns(0, 3, 1'b0);
    set_ns(1, 3, 1'b0);
    ifc.src_v_bram = 3'b000;
    ifc.inst_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("t4_cnt", 64'(ifc.stall_cnt), 64'(k - 1));
      chk("t4_to",  64'(ifc.timeout),   64'(k >= 6));
      adv();
    end
    reset            = 1'b1;
    ifc.interim_v    = 3'b001;
    ifc.interim_data = {16'h0000, 16'h0000, 16'h0099};
    adv();
    reset         = 1'b0;
    ifc.interim_v = '0;
    @(negedge clk);
    chk("t4_rcnt", 64'(ifc.stall_cnt), 64'd0);
    chk("t4_rto",  64'(ifc.timeout),   64'd0);
    chk("t4_ropv", 64'(ifc.op_v),      64'b000);
    adv();
    ifc.inst_valid = 1'b0;

    // Counter saturation.
    adv();
    set_ns(1, 0, 1'b0);
    ifc.inst_valid = 1'b1;
    repeat (260) adv();
    @(negedge clk);
    chk("t5_sat", 64'(ifc.stall_cnt), 64'd255);
    chk("t5_to",  64'(ifc.timeout),   64'd1);
    adv();
    ifc.inst_valid = 1'b0;
    adv();
    @(negedge clk);
    chk("t5_clr", 64'(ifc.stall_cnt), 64'd0);

    // No required sources: immediate fire from local memory.
    set_ns(0, 0, 1'b0);
    ifc.src_v_bram = 3'b011;
    ifc.inst_valid = 1'b1;
    @(negedge clk);
    chk("t6_fire", 64'(ifc.inst_fire), 64'd1);
    chk("t6_opv",  64'(ifc.op_v), 64'b011);
    chk("t6_op0",  64'(opd(0)), 64'h0555);
    adv();
    ifc.inst_valid = 1'b0;
    adv();
    adv();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
